// File: rtl/jt51_mmr_queue_if.sv
// CPU-side bus of the JT51 MMR write queue: write port, status and decoded replay strobes.
interface jt51_mmr_queue_if #(
  parameter int unsigned AW = 2
);
  logic          cen;
  logic [7:0]    din;
  logic [1:0]    addr;
  logic          write;
  logic          busy;
  logic          pending;
  logic          ovf;
  logic [AW:0]   level;
  logic          up_valid;
  logic          up_bank;
  logic [7:0]    up_addr;
  logic [7:0]    up_data;
  logic          up_glob;
  logic          up_chreg;
  logic          up_opreg;
  logic          up_keyon;
  logic          up_lforst;
  logic [2:0]    up_field;
  logic [1:0]    up_op;
  logic [3:0]    up_ch;

  modport master (
    output cen, din, addr, write,
    input  busy, pending, ovf, level,
    input  up_valid, up_bank, up_addr, up_data,
    input  up_glob, up_chreg, up_opreg, up_keyon, up_lforst,
    input  up_field, up_op, up_ch
  );

  modport slave (
    input  cen, din, addr, write,
    output busy, pending, ovf, level,
    output up_valid, up_bank, up_addr, up_data,
    output up_glob, up_chreg, up_opreg, up_keyon, up_lforst,
    output up_field, up_op, up_ch
  );
endinterface

// File: rtl/jt51_mmr_queue.sv
// JT51 MMR front end: buffers CPU data writes in a FIFO and replays them
// to the register file at one write per WAIT cen cycles, with decode strobes.
module jt51_mmr_queue #(
  parameter int unsigned BANKS = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WAIT  = 32,
  parameter int unsigned AW    = 2
) (
  input  logic             rst,
  input  logic             clk,
  jt51_mmr_queue_if.slave  bus
);

  localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef struct packed {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic          write_q, write_prev_q;
  logic [7:0]    din_q;
  logic [1:0]    addr_q;
  logic [7:0]    sel_q [2];
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          ovf_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;

  logic          up_valid_q, up_bank_q, up_glob_q, up_chreg_q, up_opreg_q;
  logic          up_keyon_q, up_lforst_q;
  logic [7:0]    up_addr_q, up_data_q;
  logic [2:0]    up_field_q;
  logic [1:0]    up_op_q;
  logic [3:0]    up_ch_q;

  logic          edge_c, bank_c, full_c, push_c, pop_c;
  entry_t        head_c;
  logic          dec_glob_c, dec_chreg_c, dec_opreg_c, dec_keyon_c, dec_lforst_c;
  logic [2:0]    dec_field_c;

  assign edge_c = write_q & ~write_prev_q;
  assign bank_c = (BANKS == 2) ? addr_q[1] : 1'b0;
  assign full_c = (level_q == (AW+1)'(DEPTH));
  assign push_c = edge_c & addr_q[0] & ~full_c;
  assign pop_c  = (state_q == ST_IDLE) && (level_q != '0);
  assign head_c = mem_q[rd_ptr_q];

  // Register the CPU strobe and its payload so only a rising edge acts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q      <= 1'b0;
      write_prev_q <= 1'b0;
      din_q        <= 8'h00;
      addr_q       <= 2'b00;
    end else begin
      write_q      <= bus.write;
      write_prev_q <= write_q;
      din_q        <= bus.din;
      addr_q       <= bus.addr;
    end
  end

  // Per-bank register address latches, updated immediately (never queued)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q[0] <= 8'h00;
      sel_q[1] <= 8'h00;
    end else if (edge_c && !addr_q[0]) begin
      sel_q[bank_c] <= din_q;
    end
  end

  // FIFO storage; contents are discarded on reset through the pointers
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= '{bank: bank_c, addr: sel_q[bank_c], data: din_q};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_c && !pop_c)      level_q <= level_q + (AW+1)'(1);
      else if (!push_c && pop_c) level_q <= level_q - (AW+1)'(1);
      if (edge_c && addr_q[0] && full_c) ovf_q <= 1'b1;
    end
  end

  // Classify the head entry's register address
  always_comb begin
    dec_glob_c   = 1'b0;
    dec_chreg_c  = 1'b0;
    dec_opreg_c  = 1'b0;
    dec_keyon_c  = 1'b0;
    dec_lforst_c = 1'b0;
    dec_field_c  = 3'd0;
    if (head_c.addr < 8'h20) begin
      dec_glob_c   = 1'b1;
      dec_keyon_c  = (head_c.addr == 8'h08);
      dec_lforst_c = (head_c.addr == 8'h01);
    end else if (head_c.addr < 8'h40) begin
      dec_chreg_c  = 1'b1;
      dec_field_c  = {1'b0, head_c.addr[4:3]};
    end else begin
      dec_opreg_c  = 1'b1;
      dec_field_c  = head_c.addr[7:5];
    end
  end

  // Replay pacing FSM: pop one entry, then wait WAIT cen cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      up_valid_q  <= 1'b0;
      up_glob_q   <= 1'b0;
      up_chreg_q  <= 1'b0;
      up_opreg_q  <= 1'b0;
      up_keyon_q  <= 1'b0;
      up_lforst_q <= 1'b0;
      up_bank_q   <= 1'b0;
      up_addr_q   <= 8'h00;
      up_data_q   <= 8'h00;
      up_field_q  <= 3'd0;
      up_op_q     <= 2'd0;
      up_ch_q     <= 4'd0;
    end else begin
      up_valid_q  <= 1'b0;
      up_glob_q   <= 1'b0;
      up_chreg_q  <= 1'b0;
      up_opreg_q  <= 1'b0;
      up_keyon_q  <= 1'b0;
      up_lforst_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_c) begin
            up_valid_q  <= 1'b1;
            up_glob_q   <= dec_glob_c;
            up_chreg_q  <= dec_chreg_c;
            up_opreg_q  <= dec_opreg_c;
            up_keyon_q  <= dec_keyon_c;
            up_lforst_q <= dec_lforst_c;
            up_bank_q   <= head_c.bank;
            up_addr_q   <= head_c.addr;
            up_data_q   <= head_c.data;
            up_field_q  <= dec_field_c;
            up_op_q     <= head_c.addr[4:3];
            up_ch_q     <= {head_c.bank, head_c.addr[2:0]};
            cnt_q       <= '0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.cen) begin
            if (cnt_q == CW'(WAIT - 1)) state_q <= ST_IDLE;
            else                        cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = full_c;
  assign bus.pending   = (level_q != '0) || (state_q == ST_WAIT);
  assign bus.ovf       = ovf_q;
  assign bus.level     = level_q;
  assign bus.up_valid  = up_valid_q;
  assign bus.up_bank   = up_bank_q;
  assign bus.up_addr   = up_addr_q;
  assign bus.up_data   = up_data_q;
  assign bus.up_glob   = up_glob_q;
  assign bus.up_chreg  = up_chreg_q;
  assign bus.up_opreg  = up_opreg_q;
  assign bus.up_keyon  = up_keyon_q;
  assign bus.up_lforst = up_lforst_q;
  assign bus.up_field  = up_field_q;
  assign bus.up_op     = up_op_q;
  assign bus.up_ch     = up_ch_q;

endmodule

// File: tb/tb_jt51_mmr_queue.sv
// Bench for jt51_mmr_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_jt51_mmr_queue;

  localparam int unsigned BANKS = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WAITC = 32;
  localparam int unsigned AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   rand_cen = 1'b0;

  jt51_mmr_queue_if #(.AW(AW)) bus ();

  jt51_mmr_queue #(.BANKS(BANKS), .DEPTH(DEPTH), .WAIT(WAITC), .AW(AW)) dut (
    .rst (rst),
    .clk (clk),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending writes and a cen countdown after each replay
  typedef struct packed {
    logic       bank;
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  ent_t       m_new, m_head;
  logic [7:0] msel [2];
  int         wait_left;
  int         m_lvl;
  bit         m_push;
  logic       m_wprev;
  bit         act;
  logic [1:0] act_addr;
  logic [7:0] act_din;
  logic       m_ovf;
  logic       e_valid, e_bank;
  logic [7:0] e_addr, e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      msel[0] = 8'h00; msel[1] = 8'h00;
      wait_left = 0; m_wprev = 1'b0; act = 1'b0; m_ovf = 1'b0;
      e_valid = 1'b0; e_bank = 1'b0; e_addr = 8'h00; e_data = 8'h00;
    end else begin
      m_lvl  = mq.size();
      m_push = 1'b0;
      if (act) begin
        if (!act_addr[0]) msel[act_addr[1]] = act_din;
        else if (m_lvl < DEPTH) begin
          m_push = 1'b1;
          m_new.bank = act_addr[1]; m_new.a = msel[act_addr[1]]; m_new.d = act_din;
        end else m_ovf = 1'b1;
      end
      e_valid = 1'b0;
      if (wait_left == 0 && m_lvl != 0) begin
        m_head  = mq.pop_front();
        e_valid = 1'b1; e_bank = m_head.bank; e_addr = m_head.a; e_data = m_head.d;
        wait_left = WAITC;
      end else if (wait_left > 0 && bus.cen) begin
        wait_left--;
      end
      if (m_push) mq.push_back(m_new);
      act      = bus.write && !m_wprev;
      act_addr = bus.addr;
      act_din  = bus.din;
      m_wprev  = bus.write;
    end
  end

  // Compare every output against the model on each falling edge
  logic [37:0] exp_v, act_v;
  logic        x_glob, x_chreg, x_opreg;
  logic [2:0]  x_field;
  always @(negedge clk) begin
    x_glob  = e_addr < 8'h20;
    x_chreg = (e_addr >= 8'h20) && (e_addr < 8'h40);
    x_opreg = e_addr >= 8'h40;
    x_field = x_chreg ? {1'b0, e_addr[4:3]} : (x_opreg ? e_addr[7:5] : 3'd0);
    exp_v = {e_valid, e_bank, e_addr, e_data,
             e_valid & x_glob, e_valid & x_chreg, e_valid & x_opreg,
             e_valid & (e_addr == 8'h08), e_valid & (e_addr == 8'h01),
             x_field, e_addr[4:3], e_bank, e_addr[2:0],
             (mq.size() == DEPTH), (mq.size() != 0) || (wait_left != 0), m_ovf,
             3'(mq.size())};
    act_v = {bus.up_valid, bus.up_bank, bus.up_addr, bus.up_data,
             bus.up_glob, bus.up_chreg, bus.up_opreg, bus.up_keyon, bus.up_lforst,
             bus.up_field, bus.up_op, bus.up_ch,
             bus.busy, bus.pending, bus.ovf, bus.level};
    chk("model_outputs", 64'(act_v), 64'(exp_v));
  end

  always @(negedge clk) if (rand_cen) bus.cen = 1'($urandom_range(0, 1));

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.din = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int k, output bit ok);
    k = 0; ok = 1'b0;
    while (k < budget && !ok) begin
      @(posedge clk); #1;
      k++;
      if (bus.up_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output int k);
    k = 0;
    while (bus.pending && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  int k, n;
  bit ok;

  initial begin
    bus.cen = 1'b1; bus.din = 8'h00; bus.addr = 2'b00; bus.write = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    chk("rst_valid", 64'(bus.up_valid), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Bank 0: address 0x28, data 0x4A on an idle block
    wr(2'b00, 8'h28);
    @(negedge clk);
    bus.addr = 2'b01; bus.din = 8'h4A; bus.write = 1'b1;
    @(posedge clk); #1 bus.write = 1'b0;
    wait_valid(10, k, ok);
    chk("t1_latency", 64'(k), 64'd2);
    chk("t1_chreg", 64'(bus.up_chreg), 64'd1);
    chk("t1_field", 64'(bus.up_field), 64'd1);
    chk("t1_ch", 64'(bus.up_ch), 64'd0);
    chk("t1_addr", 64'(bus.up_addr), 64'h28);
    chk("t1_data", 64'(bus.up_data), 64'h4A);

    // Four key-on writes queued during the wait, replayed 33 clk apart
    wr(2'b00, 8'h08);
    for (int i = 0; i < 4; i++) wr(2'b01, 8'(8'h78 + i));
    @(posedge clk); #1;
    chk("t2_level", 64'(bus.level), 64'd4);
    chk("t2_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      wait_valid(60, k, ok);
      chk("t2_seen", 64'(ok), 64'd1);
      chk("t2_keyon", 64'(bus.up_keyon), 64'd1);
      chk("t2_data", 64'(bus.up_data), 64'(8'h78 + i));
      if (i > 0) chk("t2_gap", 64'(k), 64'd33);
    end
    wait_idle(100, k);
    chk("t2_pending_hold", 64'(k), 64'd32);

    // Overflow: five writes while the wait runs, fifth dropped
    wr(2'b01, 8'h30);
    wait_valid(10, k, ok);
    chk("t3_first", 64'(ok), 64'd1);
    wr(2'b00, 8'h40);
    for (int i = 0; i < 5; i++) wr(2'b01, 8'(8'h91 + i));
    @(posedge clk); #1;
    chk("t3_level", 64'(bus.level), 64'd4);
    chk("t3_ovf", 64'(bus.ovf), 64'd1);
    chk("t3_busy", 64'(bus.busy), 64'd1);
    rand_cen = 1'b1;
    n = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (bus.up_valid) begin
        chk("t3_data", 64'(bus.up_data), 64'(8'h91 + n));
        n++;
      end
    end
    rand_cen = 1'b0;
    bus.cen = 1'b1;
    chk("t3_count", 64'(n), 64'd4);
    chk("t3_ovf_sticky", 64'(bus.ovf), 64'd1);
    wait_idle(100, k);
    chk("t3_idle", 64'(bus.pending), 64'd0);

    // Two banks, replay order preserved
    wr(2'b01, 8'h00);
    wait_valid(10, k, ok);
    wr(2'b10, 8'hE3);
    wr(2'b11, 8'h5F);
    wr(2'b00, 8'h60);
    wr(2'b01, 8'h11);
    wait_valid(60, k, ok);
    chk("t4a_seen", 64'(ok), 64'd1);
    chk("t4a_bank", 64'(bus.up_bank), 64'd1);
    chk("t4a_opreg", 64'(bus.up_opreg), 64'd1);
    chk("t4a_field", 64'(bus.up_field), 64'd7);
    chk("t4a_op", 64'(bus.up_op), 64'd0);
    chk("t4a_ch", 64'(bus.up_ch), 64'hB);
    chk("t4a_data", 64'(bus.up_data), 64'h5F);
    wait_valid(60, k, ok);
    chk("t4b_seen", 64'(ok), 64'd1);
    chk("t4b_bank", 64'(bus.up_bank), 64'd0);
    chk("t4b_field", 64'(bus.up_field), 64'd3);
    chk("t4b_ch", 64'(bus.up_ch), 64'h0);
    chk("t4b_addr", 64'(bus.up_addr), 64'h60);
    chk("t4b_data", 64'(bus.up_data), 64'h11);

    // write held high for 10 clk produces one push
    @(negedge clk);
    bus.addr = 2'b01; bus.din = 8'h5A; bus.write = 1'b1;
    repeat (10) @(negedge clk);
    bus.write = 1'b0;
    @(posedge clk); #1;
    chk("t5_level", 64'(bus.level), 64'd1);

    // Reset mid-wait with two entries queued
    wr(2'b01, 8'h5B);
    @(posedge clk); #1;
    chk("t6_level_pre", 64'(bus.level), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_level", 64'(bus.level), 64'd0);
    chk("t6_pending", 64'(bus.pending), 64'd0);
    chk("t6_addr", 64'(bus.up_addr), 64'd0);
    chk("t6_data", 64'(bus.up_data), 64'd0);
    chk("t6_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk) rst = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus.up_valid) n++;
    end
    chk("t6_no_replay", 64'(n), 64'd0);

    // Address latches cleared by reset: data goes to register 0x00
    wr(2'b01, 8'h33);
    wait_valid(10, k, ok);
    chk("t7_seen", 64'(ok), 64'd1);
    chk("t7_addr", 64'(bus.up_addr), 64'h00);
    chk("t7_glob", 64'(bus.up_glob), 64'd1);
    chk("t7_data", 64'(bus.up_data), 64'h33);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
